// File: rtl/bfly_tf_sequencer.sv
// Radix-16 FFT pass sequencer: walks stage/twiddle-index/beat counters,
// drives the twiddle ROM read enable and paces delivery with out_ready.
module bfly_tf_sequencer #(
    parameter int S_WIDTH    = 4,
    parameter int SC_WIDTH   = 3,
    parameter int IDX_WIDTH  = 6,
    parameter int BEAT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SC_WIDTH-1:0]   cfg_stages,
    input  logic                  out_ready,
    output logic [S_WIDTH-1:0]    state,
    output logic [SC_WIDTH-1:0]   stage_counter,
    output logic                  CEN,
    output logic [IDX_WIDTH-1:0]  tf_idx,
    output logic [BEAT_WIDTH-1:0] beat,
    output logic                  tf_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [S_WIDTH-1:0] {
        ST_IDLE  = S_WIDTH'(0),
        ST_RUN   = S_WIDTH'(2),
        ST_DRAIN = S_WIDTH'(3),
        ST_DONE  = S_WIDTH'(4),
        ST_ERR   = S_WIDTH'(5)
    } state_t;

    localparam logic [BEAT_WIDTH-1:0] BEAT_MAX = {BEAT_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0]  IDX_MAX  = {IDX_WIDTH{1'b1}};

    state_t                state_q, state_d;
    logic [SC_WIDTH-1:0]   stage_q, stage_d;
    logic [SC_WIDTH-1:0]   stages_q, stages_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [BEAT_WIDTH-1:0] beat_q, beat_d;
    logic                  tf_valid_q, tf_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  advance_s;

    // A ROM read happens exactly when RUN meets a ready datapath.
    assign advance_s = (state_q == ST_RUN) && out_ready;
    assign CEN       = ~advance_s;

    assign state         = state_q;
    assign stage_counter = stage_q;
    assign tf_idx        = idx_q;
    assign beat          = beat_q;
    assign tf_valid      = tf_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

    // Next-state and counter logic; abort overrides everything else.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        stages_d = stages_q;
        idx_d    = idx_q;
        beat_d   = beat_q;
        if (abort) begin
            state_d = ST_IDLE;
            stage_d = {SC_WIDTH{1'b0}};
            idx_d   = {IDX_WIDTH{1'b0}};
            beat_d  = {BEAT_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (cfg_stages != {SC_WIDTH{1'b0}})) begin
                        state_d  = ST_RUN;
                        stages_d = cfg_stages;
                        stage_d  = {SC_WIDTH{1'b0}};
                        idx_d    = {IDX_WIDTH{1'b0}};
                        beat_d   = {BEAT_WIDTH{1'b0}};
                    end else if (start) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (advance_s) begin
                        beat_d = beat_q + BEAT_WIDTH'(1);
                        if (beat_q == BEAT_MAX) begin
                            idx_d = idx_q + IDX_WIDTH'(1);
                            // Last index of the last stage: stage_counter keeps its final value.
                            if ((idx_q == IDX_MAX) && (stage_q == stages_q - SC_WIDTH'(1))) begin
                                state_d = ST_DRAIN;
                            end else if (idx_q == IDX_MAX) begin
                                stage_d = stage_q + SC_WIDTH'(1);
                            end else begin
                                stage_d = stage_q;
                            end
                        end else begin
                            idx_d = idx_q;
                        end
                    end else begin
                        beat_d = beat_q;
                    end
                end
                ST_DRAIN: state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                ST_ERR:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        tf_valid_d = advance_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            stage_q    <= {SC_WIDTH{1'b0}};
            stages_q   <= {SC_WIDTH{1'b0}};
            idx_q      <= {IDX_WIDTH{1'b0}};
            beat_q     <= {BEAT_WIDTH{1'b0}};
            tf_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            stages_q   <= stages_d;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            tf_valid_q <= tf_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_bfly_tf_sequencer.sv
// Directed self-checking bench for bfly_tf_sequencer.
module tb_bfly_tf_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] cfg_stages = 3'd0;
    logic       out_ready = 1'b0;
    logic [3:0] state;
    logic [2:0] stage_counter;
    logic       CEN;
    logic [5:0] tf_idx;
    logic [3:0] beat;
    logic       tf_valid;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    bfly_tf_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_stages    (cfg_stages),
        .out_ready     (out_ready),
        .state         (state),
        .stage_counter (stage_counter),
        .CEN           (CEN),
        .tf_idx        (tf_idx),
        .beat          (beat),
        .tf_valid      (tf_valid),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full pass; optional stall of stall_len cycles when advance count hits stall_adv,
    // optional stray start pulses during RUN and in the DONE cycle.
    task automatic run_pass(input int stages, input int stall_adv, input int stall_len, input bit noise);
        int  adv;
        int  cyc;
        int  stall_left;
        bit  stalled;
        bit  prev_adv;
        bit  rdy;
        start = 1'b1;
        cfg_stages = 3'(stages);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        cfg_stages = 3'd0;
        adv = 0; cyc = 1; stall_left = 0; stalled = 1'b0; prev_adv = 1'b0;
        while (adv < stages * 1024) begin
            if (adv == stall_adv && !stalled) begin
                stall_left = stall_len;
                stalled = 1'b1;
            end
            rdy = (stall_left == 0);
            out_ready = rdy;
            start = noise && (cyc == 10);
            #1;
            chk("run_state", state, 32'd2);
            chk("run_stage", stage_counter, adv / 1024);
            chk("run_idx", tf_idx, (adv / 16) % 64);
            chk("run_beat", beat, adv % 16);
            chk("run_busy", busy, 32'd1);
            chk("run_done", done, 32'd0);
            chk("run_cen", CEN, !rdy);
            chk("run_tf_valid", tf_valid, prev_adv);
            prev_adv = rdy;
            tick();
            if (rdy) adv++;
            else stall_left--;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("drain_state", state, 32'd3);
        chk("drain_stage", stage_counter, stages - 1);
        chk("drain_idx", tf_idx, 32'd0);
        chk("drain_beat", beat, 32'd0);
        chk("drain_busy", busy, 32'd1);
        chk("drain_tf_valid", tf_valid, prev_adv);
        chk("drain_done", done, 32'd0);
        chk("drain_cen", CEN, 32'd1);
        tick();
        cyc++;
        out_ready = 1'b1;
        start = noise;
        cfg_stages = 3'd1;
        #1;
        chk("done_state", state, 32'd4);
        chk("done_pulse", done, 32'd1);
        chk("done_busy", busy, 32'd0);
        chk("done_tf_valid", tf_valid, 32'd0);
        chk("done_cen", CEN, 32'd1);
        chk("done_cycle", cyc, stages * 1024 + 2 + stall_len);
        tick();
        cyc++;
        start = 1'b0;
        cfg_stages = 3'd0;
        chk("idle_state", state, 32'd0);
        chk("idle_done", done, 32'd0);
        chk("idle_busy", busy, 32'd0);
        chk("idle_cycle", cyc, stages * 1024 + 3 + stall_len);
        tick();
        chk("idle_hold_state", state, 32'd0);
        chk("idle_hold_done", done, 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 32'd0);
        chk("rst_stage", stage_counter, 32'd0);
        chk("rst_cen", CEN, 32'd1);
        chk("rst_idx", tf_idx, 32'd0);
        chk("rst_beat", beat, 32'd0);
        chk("rst_tf_valid", tf_valid, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_err", err, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_state", state, 32'd0);

        // Nominal single stage, then three stages with stray starts, then a stall
        run_pass(1, -1, 0, 1'b0);
        run_pass(3, -1, 0, 1'b1);
        run_pass(1, 7 * 16 + 15, 5, 1'b0);

        // Bad configuration
        start = 1'b1;
        cfg_stages = 3'd0;
        tick();
        start = 1'b0;
        chk("err_state", state, 32'd5);
        chk("err_pulse", err, 32'd1);
        chk("err_busy", busy, 32'd0);
        chk("err_done", done, 32'd0);
        tick();
        chk("err_back_state", state, 32'd0);
        chk("err_cleared", err, 32'd0);
        chk("err_no_done", done, 32'd0);
        tick();
        chk("err_stays_low", err, 32'd0);

        // Abort at stage 1, tf_idx 20 (with start also high to test priority)
        start = 1'b1;
        cfg_stages = 3'd3;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1024 + 20 * 16; i++) tick();
        chk("pre_abort_stage", stage_counter, 32'd1);
        chk("pre_abort_idx", tf_idx, 32'd20);
        chk("pre_abort_beat", beat, 32'd0);
        abort = 1'b1;
        start = 1'b1;
        #1;
        chk("pre_abort_cen", CEN, 32'd0);
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_state", state, 32'd0);
        chk("abort_stage", stage_counter, 32'd0);
        chk("abort_idx", tf_idx, 32'd0);
        chk("abort_beat", beat, 32'd0);
        chk("abort_busy", busy, 32'd0);
        chk("abort_done", done, 32'd0);
        chk("abort_tf_valid", tf_valid, 32'd1);
        tick();
        chk("abort_tf_valid_next", tf_valid, 32'd0);
        chk("abort_idle_state", state, 32'd0);
        chk("abort_no_done", done, 32'd0);
        run_pass(1, -1, 0, 1'b0);

        // Asynchronous reset mid-pass
        start = 1'b1;
        cfg_stages = 3'd2;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1100; i++) tick();
        chk("pre_arst_stage", stage_counter, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 32'd0);
        chk("arst_stage", stage_counter, 32'd0);
        chk("arst_idx", tf_idx, 32'd0);
        chk("arst_beat", beat, 32'd0);
        chk("arst_tf_valid", tf_valid, 32'd0);
        chk("arst_busy", busy, 32'd0);
        chk("arst_cen", CEN, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_release_state", state, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
